// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
// The optional DMEM_ARB_STATS_EN per-port grant counters live in dmem_arbiter.
package dmem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Next-owner selection for dmem_arbiter: round-robin arbitration with
// a lock that is force-released after MAX_BURST grants under contention.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  owner_t      i_owner,
    input  port_t       i_last,
    input  logic [1:0]  i_req,
    input  logic [1:0]  i_lock,
    input  logic [1:0]  i_gnt,
    input  logic [7:0]  i_burst_cnt,
    output owner_t      o_next_owner
);

    logic  w_under_cap;
    port_t w_last_eff;

    always_comb begin
        w_under_cap  = ({1'b0, i_burst_cnt} + 9'd1) < 9'(MAX_BURST);
        // A grant this cycle counts as the latest winner, so a tie on the
        // following edge goes to the other port without a bubble.
        w_last_eff   = i_last;
        if (i_gnt[0]) begin
            w_last_eff = PORT_A;
        end else if (i_gnt[1]) begin
            w_last_eff = PORT_B;
        end

        o_next_owner = IDLE;
        if (i_owner == OWN_A && i_gnt[0] && i_lock[0]) begin
            o_next_owner = (!i_req[1] || w_under_cap) ? OWN_A : OWN_B;
        end else if (i_owner == OWN_B && i_gnt[1] && i_lock[1]) begin
            o_next_owner = (!i_req[0] || w_under_cap) ? OWN_B : OWN_A;
        end else if (i_req[0] && i_req[1]) begin
            o_next_owner = (w_last_eff == PORT_A) ? OWN_B : OWN_A;
        end else if (i_req[0]) begin
            o_next_owner = OWN_A;
        end else if (i_req[1]) begin
            o_next_owner = OWN_B;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port 256x8 data memory between port A and port B.
// Define DMEM_ARB_STATS_EN to add the cnt_a/cnt_b grant counters.
//
// owner  | meaning
// IDLE   | no owner, nothing granted this cycle
// OWN_A  | port A owns the memory, granted while req_a is high
// OWN_B  | port B owns the memory, granted while req_b is high
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic              lock_a,
    input  logic              lock_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdat_a,
    input  logic [DATA_W-1:0] wdat_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic [DATA_W-1:0] rdat_a,
    output logic [DATA_W-1:0] rdat_b,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dat_in,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    input  logic [DATA_W-1:0] mem_dat_out
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       cnt_a,
    output logic [15:0]       cnt_b
`endif
);

    owner_t     r_owner;
    port_t      r_last;
    logic [7:0] r_burst_cnt;

    owner_t     w_next_owner;
    logic [7:0] w_burst_nxt;
    logic       w_gnt_a;
    logic       w_gnt_b;

    // Grants are masked during reset so an in-flight write cannot commit.
    assign w_gnt_a = reset_n && (r_owner == OWN_A) && req_a;
    assign w_gnt_b = reset_n && (r_owner == OWN_B) && req_b;
    assign gnt_a   = w_gnt_a;
    assign gnt_b   = w_gnt_b;

    dmem_arb_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .i_owner      (r_owner),
        .i_last       (r_last),
        .i_req        ({req_b, req_a}),
        .i_lock       ({lock_b, lock_a}),
        .i_gnt        ({w_gnt_b, w_gnt_a}),
        .i_burst_cnt  (r_burst_cnt),
        .o_next_owner (w_next_owner)
    );

    always_comb begin
        w_burst_nxt = '0;
        if ((w_gnt_a && lock_a && w_next_owner == OWN_A) ||
            (w_gnt_b && lock_b && w_next_owner == OWN_B)) begin
            w_burst_nxt = sat_inc8(r_burst_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_owner     <= IDLE;
            r_last      <= PORT_B;
            r_burst_cnt <= '0;
        end else begin
            r_owner     <= w_next_owner;
            r_burst_cnt <= w_burst_nxt;
            if (w_gnt_a) begin
                r_last <= PORT_A;
            end else if (w_gnt_b) begin
                r_last <= PORT_B;
            end
        end
    end

    always_comb begin
        mem_addr   = '0;
        mem_dat_in = '0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        rdat_a     = '0;
        rdat_b     = '0;
        if (w_gnt_a) begin
            mem_addr   = addr_a;
            mem_dat_in = wdat_a;
            mem_wr_en  = we_a;
            mem_rd_en  = !we_a;
            rdat_a     = we_a ? '0 : mem_dat_out;
        end else if (w_gnt_b) begin
            mem_addr   = addr_b;
            mem_dat_in = wdat_b;
            mem_wr_en  = we_b;
            mem_rd_en  = !we_b;
            rdat_b     = we_b ? '0 : mem_dat_out;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] r_cnt_a;
    logic [15:0] r_cnt_b;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (w_gnt_a) begin
                r_cnt_a <= r_cnt_a + 16'd1;
            end
            if (w_gnt_b) begin
                r_cnt_b <= r_cnt_b + 16'd1;
            end
        end
    end

    assign cnt_a = r_cnt_a;
    assign cnt_b = r_cnt_b;
`endif

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the single-port 256×8 data memory. It shares the memory between the core's load/store port (A) and the loader/DMA port (B). Arbitration is round-robin with an optional burst lock and a bounded burst length. The block sits between the two requesters and the memory: it drives the memory's address, write data, read-enable and write-enable, and returns the combinational read data to the granted requester.

## Interface
Parameters:
- MAX_BURST, 16: maximum consecutive locked grants to one owner while the other port is requesting; legal range 1–255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- req_a / req_b  in  1  access request, port A / port B
- we_a / we_b  in  1  1 = write, 0 = read
- lock_a / lock_b  in  1  keep ownership after this access
- addr_a / addr_b  in  8  byte address
- wdat_a / wdat_b  in  8  write data
- gnt_a / gnt_b  out  1  access performed this cycle
- rdat_a / rdat_b  out  8  read data; valid when gnt_x=1 and we_x=0, otherwise 0
- mem_addr  out  8  memory address
- mem_dat_in  out  8  memory write data
- mem_rd_en  out  1  memory read enable
- mem_wr_en  out  1  memory write enable
- mem_dat_out  in  8  memory read data (combinational)

## Operation
- State register `owner` ∈ {IDLE, OWN_A, OWN_B}.
- Round-robin pointer `last` ∈ {A, B}.
- Burst counter `burst_cnt`, 8 bits.

Grant and memory drive:
- gnt_x = (owner == OWN_x) & req_x.
- When gnt_x=1, the memory is driven from port x:
  - mem_addr = addr_x, mem_dat_in = wdat_x
  - mem_wr_en = we_x, mem_rd_en = ~we_x
  - rdat_x = mem_dat_out; the other port's rdat = 0.
- With no grant: mem_rd_en = mem_wr_en = 0, mem_addr = 0, mem_dat_in = 0.

Next-owner selection, evaluated every cycle:
- Current owner x granted with lock_x=1:
  - If the other port is not requesting, stay.
  - If burst_cnt+1 < MAX_BURST, stay.
  - Otherwise switch to the other port (forced release).
- Otherwise:
  - Both requesting: pick the port ≠ `last`.
  - One requesting: pick that port.
  - None requesting: IDLE.
- The current owner with an unlocked grant and no competing request stays owner, allowing back-to-back accesses.
- `last` updates to x on every grant to x.

Burst counter:
- Increments on each consecutive grant to the same owner with lock=1.
- Clears on an owner change, on an unlocked grant, or on IDLE.
- Saturates at 255.

Other rules:
- A requester must hold req/we/addr/wdat/lock stable until it samples gnt=1.
- Dropping req while owner is legal: no access occurs and the arbiter re-arbitrates on the next edge.
- Reset values: owner=IDLE, last=B (so A wins the first tie), burst_cnt=0, all gnt=0, mem_rd_en=mem_wr_en=0, rdat_a=rdat_b=0, mem_addr=mem_dat_in=0.
- Reset mid-access: the write is suppressed in the reset cycle, because gnt is forced 0 while reset_n=0.

## Timing
- From IDLE: req_x is sampled at edge n, and gnt_x=1 in cycle n+1.
- Read data is valid combinationally in that same cycle; a write commits at the end of that cycle.
- A continuously requesting sole owner gets one access per cycle.
- Owner handoff: one access per cycle, with no bubble between A and B when both are requesting.
- Worst-case wait for a requester: MAX_BURST cycles.

## Configuration
- Macro: DMEM_ARB_STATS_EN.
- Defined: adds outputs cnt_a and cnt_b (16 bits each, out), counting granted accesses per port. They wrap modulo 2^16 and reset to 0.
- Not defined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Package dmem_arb_pkg holds:
  - owner_t enum {IDLE, OWN_A, OWN_B}
  - port_t enum {PORT_A, PORT_B}
  - ADDR_W=8, DATA_W=8
- One sub-module, dmem_arb_pick: combinational next-owner and forced-release logic. Its inputs are owner, last, req, lock, gnt and burst_cnt; its output is next owner.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with req_a=1, we_a=1 → gnt_a=0 and mem_wr_en=0 throughout; after release, gnt_a=1 on the second edge.
- Single read: req_a=1, addr_a=0x3C, memory holds 0xA5 → one cycle later gnt_a=1, mem_rd_en=1, rdat_a=0xA5, rdat_b=0.
- Contention after reset: req_a=req_b=1, unlocked, held → grants alternate A,B,A,B, with exactly one gnt per cycle and no idle cycle.
- Burst cap with MAX_BURST=4: lock_a=1 continuous, then req_b rises mid-burst → at most 4 consecutive gnt_a while req_b is high, then gnt_b=1; a write by B to 0x10 of 0x77 reads back 0x77 via A.
- Drop request: owner A deasserts req_a with B idle → gnt_a=0, no memory enables, owner=IDLE on the next edge.
- DMEM_ARB_STATS_EN: 5 A writes and 3 B reads → cnt_a=5, cnt_b=3; reset clears both to 0.
